// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and helpers for the stall/flush controller and the md-group decoder.
// Pure declarations: no state, no latency, no flow control.
package hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE    = 2'd3;
  localparam int         MULT_CYC_DEF = 5;
  localparam int         DIV_CYC_DEF  = 10;

  // SPECIAL-opcode funct codes that make up the mult/div group
  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  function automatic logic is_md_instr(input logic [5:0] opcode, input logic [5:0] funct);
    logic md_funct;
    md_funct = (funct == FUNCT_MFHI)  || (funct == FUNCT_MTHI)  ||
               (funct == FUNCT_MFLO)  || (funct == FUNCT_MTLO)  ||
               (funct == FUNCT_MULT)  || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)   || (funct == FUNCT_DIVU);
    return (opcode == OP_SPECIAL) && md_funct;
  endfunction

  // A source stalls when a later-stage producer's result arrives after the source is consumed
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] wa,  input logic [1:0] tnew);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (src == wa) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy countdown; md_busy covers the start cycle plus the configured latency.
// Latency: busy is combinational on the start pulse; no backpressure, a start reloads the count.
module md_busy_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0] md_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (md_start) begin
      md_cnt <= md_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  // Gated by reset so busy (and any md stall) drops the moment reset asserts
  assign md_busy = reset && ((md_cnt != '0) || md_start);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: Tuse/Tnew data hazards plus mult/div busy stalls.
// Latency: enables/flush are combinational (zero added latency); stall counter saturates.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs_addr,
  input  logic [4:0]       D_rt_addr,
  input  logic [1:0]       D_rs_tuse,
  input  logic [1:0]       D_rt_tuse,
  input  logic             D_is_md,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_tnew,
  input  logic             E_md_start,
  input  logic             E_md_is_div,
  output logic             PC_en,
  output logic             D_en,
  output logic             E_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic stall_rs_E, stall_rs_M, stall_rt_E, stall_rt_M;
  logic stall_data, stall_md, stall;

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md (
    .clk       (clk),
    .reset     (reset),
    .md_start  (E_md_start),
    .md_is_div (E_md_is_div),
    .md_busy   (md_busy)
  );

  assign stall_rs_E = src_hazard(D_rs_addr, D_rs_tuse, E_wa, E_tnew);
  assign stall_rs_M = src_hazard(D_rs_addr, D_rs_tuse, M_wa, M_tnew);
  assign stall_rt_E = src_hazard(D_rt_addr, D_rt_tuse, E_wa, E_tnew);
  assign stall_rt_M = src_hazard(D_rt_addr, D_rt_tuse, M_wa, M_tnew);

  assign stall_data = stall_rs_E || stall_rs_M || stall_rt_E || stall_rt_M;
  assign stall_md   = D_is_md && md_busy;
  assign stall      = reset && (stall_data || stall_md);

  // D holds and a bubble enters E in the same cycle
  assign PC_en   = !stall;
  assign D_en    = !stall;
  assign E_flush = stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench: stimulus pushes hand-computed expectations, a negedge monitor checks them.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
  logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic        D_is_md, E_md_start, E_md_is_div;
  logic        PC_en, D_en, E_flush, md_busy;
  logic [31:0] stall_cnt;
  logic        s_PC_en, s_D_en, s_E_flush, s_md_busy;
  logic [3:0]  s_stall_cnt;

  typedef struct packed {
    logic        stall;
    logic        busy;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .D_is_md(D_is_md), .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
    .PC_en(PC_en), .D_en(D_en), .E_flush(E_flush), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation
  hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .D_is_md(D_is_md), .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
    .PC_en(s_PC_en), .D_en(s_D_en), .E_flush(s_E_flush), .md_busy(s_md_busy), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_miss++;
      $display("FAIL vec%0d %s: got %0h, expected %0h", n_vec, name, act, req);
    end
  endtask

  // Monitor: one output set per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      chk("PC_en",       {31'd0, PC_en},     {31'd0, ~e.stall});
      chk("D_en",        {31'd0, D_en},      {31'd0, ~e.stall});
      chk("E_flush",     {31'd0, E_flush},   {31'd0, e.stall});
      chk("md_busy",     {31'd0, md_busy},   {31'd0, e.busy});
      chk("stall_cnt",   stall_cnt,          e.cnt);
      chk("sat_E_flush", {31'd0, s_E_flush}, {31'd0, e.stall});
      chk("sat_cnt",     {28'd0, s_stall_cnt}, {28'd0, e.cnt4});
    end
    if (reset && E_md_start)
      assert (dut.u_md.md_cnt == '0) else $error("FAIL md start while busy");
  end

  task automatic step(input logic es, input logic eb, input int ec);
    exp_t e;
    e.stall = es;
    e.busy  = eb;
    e.cnt   = 32'(ec);
    e.cnt4  = (ec > 15) ? 4'd15 : 4'(ec);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_rs_addr = 5'd0; D_rt_addr = 5'd0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
    D_is_md = 1'b0; E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd0; M_tnew = 2'd0;
    E_md_start = 1'b0; E_md_is_div = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    @(posedge clk);
    #1;
    // Reset state, including a start pulse that must not show busy
    step(0, 0, 0);
    E_md_start = 1'b1; D_is_md = 1'b1;
    step(0, 0, 0);
    idle();
    reset = 1'b1;
    step(0, 0, 0);

    // Load-use on rs from E, then resolved one cycle later
    E_wa = 5'd8; E_tnew = 2'd2; D_rs_addr = 5'd8; D_rs_tuse = 2'd1;
    step(1, 0, 0);
    E_tnew = 2'd1;
    step(0, 0, 1);
    idle();
    M_wa = 5'd8; M_tnew = 2'd1; D_rs_addr = 5'd8; D_rs_tuse = 2'd0;
    step(1, 0, 1);
    D_rs_tuse = 2'd1;
    step(0, 0, 2);

    // $0 and unused sources never stall
    idle();
    D_rs_addr = 5'd0; D_rs_tuse = 2'd0; E_wa = 5'd0; E_tnew = 2'd2;
    step(0, 0, 2);
    idle();
    D_rt_addr = 5'd9; D_rt_tuse = 2'd3; E_wa = 5'd9; E_tnew = 2'd2;
    step(0, 0, 2);
    D_rt_tuse = 2'd1;
    step(1, 0, 2);

    // mult then mfhi held in D: start cycle + 5 stalled cycles
    idle();
    D_is_md = 1'b1; E_md_start = 1'b1;
    step(1, 1, 3);
    E_md_start = 1'b0;
    for (int i = 0; i < 5; i++) step(1, 1, 4 + i);
    step(0, 0, 9);

    // div with nothing md in D: busy 11 cycles, no stalls
    idle();
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    step(0, 1, 9);
    E_md_start = 1'b0; E_md_is_div = 1'b0;
    for (int i = 0; i < 10; i++) step(0, 1, 9);
    step(0, 0, 9);

    // div with md in D, reset asserted at cycle 4 of the countdown
    D_is_md = 1'b1; E_md_start = 1'b1; E_md_is_div = 1'b1;
    step(1, 1, 9);
    E_md_start = 1'b0; E_md_is_div = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 1, 10 + i);
    reset = 1'b0;
    step(0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0);

    // Data and md stall together count once per cycle
    idle();
    M_wa = 5'd5; M_tnew = 2'd1; D_rt_addr = 5'd5; D_rt_tuse = 2'd0;
    D_is_md = 1'b1; E_md_start = 1'b1;
    step(1, 1, 0);
    E_md_start = 1'b0;
    for (int i = 0; i < 5; i++) step(1, 1, 1 + i);
    step(1, 0, 6);
    idle();
    step(0, 0, 7);

    // 20 stalled cycles: wide counter keeps counting, narrow one sticks at 15
    E_wa = 5'd8; E_tnew = 2'd2; D_rs_addr = 5'd8; D_rs_tuse = 2'd0;
    for (int i = 0; i < 20; i++) step(1, 0, 7 + i);
    idle();
    step(0, 0, 27);
    step(0, 0, 27);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation time 20000 reached, expected finish earlier");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Stall/flush controller for the five-stage pipeline registers.
- Compares decode-stage source registers and their Tuse against the E/M destinations and their Tnew.
- Tracks the multi-cycle mult/div unit with an internal busy countdown.
- Drives the enable of the PC and the F/D register, and the flush (bubble) of the D/E register.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MULT_CYC, 5, busy cycles after a mult/multu start in E
DIV_CYC, 10, busy cycles after a div/divu start in E
CNT_W, 32, width of the stall performance counter

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-low reset
D_rs_addr  input  5  rs field of the instruction in D
D_rt_addr  input  5  rt field of the instruction in D
D_rs_tuse  input  2  cycles until rs is consumed: 0..2; 3 means unused
D_rt_tuse  input  2  same encoding, for rt
D_is_md  input  1  D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
E_wa  input  5  destination register in E; 0 means none
E_tnew  input  2  cycles until E's result is available: 0..2
M_wa  input  5  destination register in M
M_tnew  input  2  cycles until M's result is available: 0..1
E_md_start  input  1  mult/div start pulse, valid while the instr is in E
E_md_is_div  input  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu
PC_en  output  1  PC write enable
D_en  output  1  F/D register enable
E_flush  output  1  load a NOP into the D/E register
md_busy  output  1  mult/div unit is occupied
stall_cnt  output  CNT_W  number of stalled cycles since reset

Behaviour:
- Reset (reset=0, asynchronous):
  - md_cnt=0, stall_cnt=0.
  - Outputs during reset: PC_en=1, D_en=1, E_flush=0, md_busy=0.
- Data-hazard terms, combinational, evaluated separately for rs and rt:
  - A term is suppressed when its address is 0 or its tuse is 3.
  - stall_rs_E = (D_rs_addr==E_wa) && (E_tnew > D_rs_tuse); stall_rs_M uses M_wa/M_tnew.
  - stall_rt_E and stall_rt_M are defined the same way with D_rt_addr/D_rt_tuse.
- md_busy = (md_cnt != 0) || E_md_start.
- stall_md = D_is_md && md_busy.
- stall = OR of all data-hazard terms and stall_md.
- Stall effect: PC_en = D_en = ~stall; E_flush = stall. The bubble enters E while D holds, in the same cycle; there is no added latency.
- md_cnt, registered countdown:
  - On E_md_start, load DIV_CYC if E_md_is_div, else MULT_CYC.
  - Otherwise decrement while nonzero; hold at 0.
  - A start while md_cnt!=0 reloads the counter. The upstream stall guarantees this cannot happen and the bench asserts it.
- Busy timing: after a mult start at edge t, md_busy is high for that start cycle plus MULT_CYC cycles.
  - An mfhi held in D issues in the first cycle with md_cnt==0.
- stall_cnt: increments on every clk edge where stall=1 and reset=1; saturates at all-ones, with no wrap.
- Simultaneous data and md stall: a single stall; stall_cnt increments by 1.
- Reset asserted mid-countdown: md_cnt clears immediately and stall drops in the same cycle.
- No registered path from stall to the enables: the block adds no pipeline latency.

Decomposition:
- Shared package constants:
  - TUSE_NONE=2'd3.
  - MULT_CYC and DIV_CYC defaults.
  - Opcode/funct constants for the md group, consumed by the decoder that produces D_is_md.
- One natural sub-module, md_busy_counter: holds the md_cnt load/decrement logic and md_busy. Everything else stays in hazard_ctrl.

Test Plan:
1. Load-use: E_wa=8, E_tnew=2, D_rs_addr=8, D_rs_tuse=1 -> PC_en=0, D_en=0, E_flush=1 for exactly 1 cycle (next cycle E_tnew=1, no stall); stall_cnt=1.
2. $0 and unused source: D_rs_addr=0 matching E_wa=0 with E_tnew=2 -> no stall. D_rt_tuse=3 with an rt address match -> no stall.
3. mult then mfhi: E_md_start=1, E_md_is_div=0 at cycle 0, D_is_md=1 held -> stall for 6 cycles (start cycle + 5), D_en=1 in cycle 6; stall_cnt=6.
4. div: E_md_is_div=1 -> md_busy high 11 cycles. Assert reset=0 at cycle 4 -> md_busy=0 and stall_cnt=0 immediately; PC_en=1.
5. Combined: M_wa=5, M_tnew=1, D_rt_addr=5, D_rt_tuse=0, with md_busy=1 and D_is_md=1 -> one stall; stall_cnt increments by exactly 1 per cycle.
6. Saturation: CNT_W=4, hold stall for 20 cycles -> stall_cnt stops at 15 and stays there.
